// File: rtl/fifo_sync_param_if.sv
// Bundle of the FIFO's data, request and status signals. The FIFO side uses
// the slave modport; whoever feeds and drains the FIFO uses master.
//
// Handshake: rx_irq offers rx_data for one edge and is taken when the FIFO is
// not full, or is full but pops on that same edge. tx_irq pops a word when
// the FIFO is not empty. Rejected requests raise sticky error flags rather
// than stalling. tx_valid qualifies tx_data: it pulses for one cycle per pop
// in registered mode, and follows !Empty_Flag in first-word-fall-through mode.
interface fifo_sync_param_if #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 10
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [DATA_WIDTH-1:0] rx_data;
  logic                  rx_irq;
  logic                  tx_irq;
  logic                  clear_err;
  logic [DATA_WIDTH-1:0] tx_data;
  logic                  tx_valid;
  logic [PTR_W-1:0]      write_pointer_out;
  logic [PTR_W-1:0]      read_pointer_out;
  logic [CNT_W-1:0]      count_out;
  logic                  Empty_Flag;
  logic                  Full_Flag;
  logic                  Almost_Empty_Flag;
  logic                  Almost_Full_Flag;
  logic                  overflow_err;
  logic                  underflow_err;

  modport master (
    output rx_data, rx_irq, tx_irq, clear_err,
    input  tx_data, tx_valid, write_pointer_out, read_pointer_out, count_out,
    input  Empty_Flag, Full_Flag, Almost_Empty_Flag, Almost_Full_Flag,
    input  overflow_err, underflow_err
  );

  modport slave (
    input  rx_data, rx_irq, tx_irq, clear_err,
    output tx_data, tx_valid, write_pointer_out, read_pointer_out, count_out,
    output Empty_Flag, Full_Flag, Almost_Empty_Flag, Almost_Full_Flag,
    output overflow_err, underflow_err
  );
endinterface

// File: rtl/fifo_sync_param.sv
// Parametrised single-clock FIFO buffering rx words for the tx path.
// Any depth >= 2 (power of two not required), occupancy count, threshold
// flags, sticky overflow/underflow errors and an optional first-word-fall-
// through read mode. The storage array is deliberately not reset.
module fifo_sync_param #(
  parameter int DATA_WIDTH    = 8,
  parameter int DEPTH         = 10,
  parameter int AFULL_THRESH  = 8,
  parameter int AEMPTY_THRESH = 2,
  parameter int FWFT          = 0
) (
  input  logic             clock,
  input  logic             reset_n,
  fifo_sync_param_if.slave bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] AFULL_C  = CNT_W'(AFULL_THRESH);
  localparam logic [CNT_W-1:0] AEMPTY_C = CNT_W'(AEMPTY_THRESH);

  // Refuse to build with thresholds or depth that make the flags meaningless.
  generate
    if (DATA_WIDTH < 1 || DEPTH < 2 ||
        AFULL_THRESH < 1 || AFULL_THRESH > DEPTH ||
        AEMPTY_THRESH < 0 || AEMPTY_THRESH > DEPTH - 1 ||
        (FWFT != 0 && FWFT != 1)) begin : g_bad_params
      $error("fifo_sync_param: parameter out of range");
    end
  endgenerate

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0]      wp;
  logic [PTR_W-1:0]      rp;
  logic [CNT_W-1:0]      count;
  logic                  empty;
  logic                  full;
  logic                  wr_ok;
  logic                  rd_ok;
  logic                  ovf_set;
  logic                  unf_set;
  logic                  ovf_q;
  logic                  unf_q;
  logic [DATA_WIDTH-1:0] tx_data_w;
  logic                  tx_valid_w;

  // Every flag comes from the registered count, so flags never glitch on requests.
  assign empty = (count == '0);
  assign full  = (count == DEPTH_C);

  // A write at full is allowed only because the same edge frees a slot.
  // A read at empty is never bypassed from the write path.
  assign rd_ok   = bus.tx_irq & ~empty;
  assign wr_ok   = bus.rx_irq & (~full | rd_ok);
  assign ovf_set = bus.rx_irq & ~wr_ok;
  assign unf_set = bus.tx_irq & empty;

  // Storage write; a rejected write touches nothing.
  always_ff @(posedge clock) begin
    if (wr_ok) begin
      mem[wp] <= bus.rx_data;
    end
  end

  // Pointers wrap at DEPTH-1 explicitly, so non power-of-two depths work.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (wr_ok) begin
        wp <= (wp == LAST_PTR) ? '0 : wp + 1'b1;
      end
      if (rd_ok) begin
        rp <= (rp == LAST_PTR) ? '0 : rp + 1'b1;
      end
    end
  end

  // Occupancy moves only when exactly one of write/read is accepted.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else begin
      case ({wr_ok, rd_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Sticky error flags; a new error on the clearing edge takes priority.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_set | (ovf_q & ~bus.clear_err);
      unf_q <= unf_set | (unf_q & ~bus.clear_err);
    end
  end

  generate
    if (FWFT != 0) begin : g_fwft
      // Head word is shown directly; zero while empty so reset shows zero.
      assign tx_data_w  = empty ? '0 : mem[rp];
      assign tx_valid_w = ~empty;
    end else begin : g_registered
      logic [DATA_WIDTH-1:0] tx_data_q;
      logic                  tx_valid_q;

      // Capture the popped word; the nonblocking read sees pre-write contents,
      // which is what makes a simultaneous write/read at full return the oldest word.
      always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
          tx_data_q  <= '0;
          tx_valid_q <= 1'b0;
        end else begin
          tx_valid_q <= rd_ok;
          if (rd_ok) begin
            tx_data_q <= mem[rp];
          end
        end
      end

      assign tx_data_w  = tx_data_q;
      assign tx_valid_w = tx_valid_q;
    end
  endgenerate

  assign bus.tx_data           = tx_data_w;
  assign bus.tx_valid          = tx_valid_w;
  assign bus.write_pointer_out = wp;
  assign bus.read_pointer_out  = rp;
  assign bus.count_out         = count;
  assign bus.Empty_Flag        = empty;
  assign bus.Full_Flag         = full;
  assign bus.Almost_Empty_Flag = (count <= AEMPTY_C);
  assign bus.Almost_Full_Flag  = (count >= AFULL_C);
  assign bus.overflow_err      = ovf_q;
  assign bus.underflow_err     = unf_q;
endmodule

// File: tb/tb_fifo_sync_param.sv
// Bench for fifo_sync_param: a registered-read instance and an FWFT instance
// receive identical stimulus and are held against a queue-based model.
module tb_fifo_sync_param;
  localparam int DW    = 8;
  localparam int DEPTH = 10;
  localparam int AF    = 8;
  localparam int AE    = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset_n = 1'b1;
  always #5 clk = ~clk;

  fifo_sync_param_if #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) bus0 ();
  fifo_sync_param_if #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) bus1 ();

  fifo_sync_param #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .AFULL_THRESH(AF),
                    .AEMPTY_THRESH(AE), .FWFT(0)) dut0 (
    .clock(clk), .reset_n(reset_n), .bus(bus0));

  fifo_sync_param #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .AFULL_THRESH(AF),
                    .AEMPTY_THRESH(AE), .FWFT(1)) dut1 (
    .clock(clk), .reset_n(reset_n), .bus(bus1));

  // ---------------- model and scoreboard ----------------
  logic [DW-1:0] mq[$];      // FIFO contents, oldest first
  logic [DW-1:0] exp_q[$];   // words the registered instance must present
  logic [DW-1:0] exp_f[$];   // words the FWFT instance must hand over on pop
  int            wp_m, rp_m;
  logic          ov_m, un_m, v0_m;
  logic [DW-1:0] d0_m;
  logic          mon_en = 1'b0;
  int            checks = 0;
  int            errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_common(input string tag, input logic [3:0] wp, input logic [3:0] rp,
                            input logic [3:0] cnt, input logic e, input logic f,
                            input logic ae, input logic af, input logic ov, input logic un);
    int sz;
    sz = mq.size();
    chk({tag, "_count"}, 32'(cnt), 32'(sz));
    chk({tag, "_empty"}, 32'(e), 32'(sz == 0));
    chk({tag, "_full"}, 32'(f), 32'(sz == DEPTH));
    chk({tag, "_aempty"}, 32'(ae), 32'(sz <= AE));
    chk({tag, "_afull"}, 32'(af), 32'(sz >= AF));
    chk({tag, "_ovf"}, 32'(ov), 32'(ov_m));
    chk({tag, "_unf"}, 32'(un), 32'(un_m));
    chk({tag, "_wp"}, 32'(wp), 32'(wp_m));
    chk({tag, "_rp"}, 32'(rp), 32'(rp_m));
  endtask

  task automatic check_all(input bit in_reset);
    chk_common("d0", bus0.write_pointer_out, bus0.read_pointer_out, bus0.count_out,
               bus0.Empty_Flag, bus0.Full_Flag, bus0.Almost_Empty_Flag,
               bus0.Almost_Full_Flag, bus0.overflow_err, bus0.underflow_err);
    chk_common("d1", bus1.write_pointer_out, bus1.read_pointer_out, bus1.count_out,
               bus1.Empty_Flag, bus1.Full_Flag, bus1.Almost_Empty_Flag,
               bus1.Almost_Full_Flag, bus1.overflow_err, bus1.underflow_err);
    chk("d0_tx_valid", 32'(bus0.tx_valid), 32'(v0_m));
    chk("d0_tx_data", 32'(bus0.tx_data), 32'(d0_m));
    chk("d1_tx_valid", 32'(bus1.tx_valid), 32'(mq.size() != 0));
    if (mq.size() != 0) chk("d1_tx_data_head", 32'(bus1.tx_data), 32'(mq[0]));
    else if (in_reset)  chk("d1_tx_data_reset", 32'(bus1.tx_data), 32'd0);
  endtask

  // ---------------- driver tasks ----------------
  task automatic set_inputs(input logic rx, input logic tx, input logic [DW-1:0] d,
                            input logic clr);
    bus0.rx_irq = rx; bus0.tx_irq = tx; bus0.rx_data = d; bus0.clear_err = clr;
    bus1.rx_irq = rx; bus1.tx_irq = tx; bus1.rx_data = d; bus1.clear_err = clr;
  endtask

  // One clock of stimulus; the model applies the FIFO rules to its queue.
  task automatic drive(input logic rx, input logic tx, input logic [DW-1:0] d,
                       input logic clr);
    int       sz;
    bit       rd_ok, wr_ok;
    logic [DW-1:0] v;
    @(negedge clk);
    set_inputs(rx, tx, d, clr);
    sz    = mq.size();
    rd_ok = tx && (sz > 0);
    wr_ok = rx && ((sz < DEPTH) || rd_ok);
    ov_m  = (rx && !wr_ok) ? 1'b1 : (clr ? 1'b0 : ov_m);
    un_m  = (tx && sz == 0) ? 1'b1 : (clr ? 1'b0 : un_m);
    v0_m  = rd_ok;
    if (rd_ok) begin
      v = mq.pop_front();
      exp_q.push_back(v);
      exp_f.push_back(v);
      d0_m = v;
      rp_m = (rp_m + 1) % DEPTH;
    end
    if (wr_ok) begin
      mq.push_back(d);
      wp_m = (wp_m + 1) % DEPTH;
    end
    @(posedge clk);
    #1;
    check_all(1'b0);
  endtask

  // Asynchronous reset pulse between clock edges, checked before any edge.
  task automatic do_reset();
    @(negedge clk);
    set_inputs(1'b0, 1'b0, '0, 1'b0);
    #2;
    reset_n = 1'b0;
    mq.delete();
    wp_m = 0; rp_m = 0; ov_m = 1'b0; un_m = 1'b0; v0_m = 1'b0; d0_m = '0;
    #1;
    check_all(1'b1);
    mon_en = 1'b1;
    @(negedge clk);
    #2;
    reset_n = 1'b1;
  endtask

  // ---------------- monitors ----------------
  // Registered instance: every tx_valid pulse must match the next expected word.
  always @(posedge clk) begin
    #1;
    if (mon_en && reset_n && bus0.tx_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL d0_unexpected_output actual=0x%0h expected=none", bus0.tx_data);
      end else begin
        chk("d0_rd_data", 32'(bus0.tx_data), 32'(exp_q.pop_front()));
      end
    end
  end

  // FWFT instance: the word shown while tx_irq is high is the one popped.
  always @(negedge clk) begin
    #1;
    if (mon_en && reset_n && bus1.tx_irq === 1'b1 && bus1.tx_valid === 1'b1) begin
      if (exp_f.size() == 0) begin
        checks++; errors++;
        $display("FAIL d1_unexpected_pop actual=0x%0h expected=none", bus1.tx_data);
      end else begin
        chk("d1_rd_data", 32'(bus1.tx_data), 32'(exp_f.pop_front()));
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int wr_pct, rd_pct;
    set_inputs(1'b0, 1'b0, '0, 1'b0);
    do_reset();

    // Reset mid-fill with five words stored.
    for (int i = 0; i < 5; i++) drive(1'b1, 1'b0, DW'(8'h30 + i), 1'b0);
    do_reset();

    // Fill to full, overflow attempt, then drain in order.
    for (int i = 1; i <= 10; i++) drive(1'b1, 1'b0, DW'(i), 1'b0);
    drive(1'b1, 1'b0, 8'hFF, 1'b0);
    for (int i = 0; i < 10; i++) drive(1'b0, 1'b1, '0, 1'b0);
    drive(1'b0, 1'b0, '0, 1'b1);

    // Pointer wrap: write 7, read 7, write 7, read 7.
    do_reset();
    for (int i = 0; i < 7; i++) drive(1'b1, 1'b0, DW'(8'h40 + i), 1'b0);
    for (int i = 0; i < 7; i++) drive(1'b0, 1'b1, '0, 1'b0);
    for (int i = 0; i < 7; i++) drive(1'b1, 1'b0, DW'(8'h11 + i), 1'b0);
    for (int i = 0; i < 7; i++) drive(1'b0, 1'b1, '0, 1'b0);

    // Simultaneous write/read at full, then at empty.
    for (int i = 0; i < 10; i++) drive(1'b1, 1'b0, DW'(8'h60 + i), 1'b0);
    drive(1'b1, 1'b1, 8'hAA, 1'b0);
    for (int i = 0; i < 10; i++) drive(1'b0, 1'b1, '0, 1'b0);
    drive(1'b1, 1'b1, 8'h77, 1'b0);
    drive(1'b0, 1'b1, '0, 1'b1);

    // Sticky error clear and set-wins-over-clear.
    drive(1'b0, 1'b1, '0, 1'b0);
    drive(1'b0, 1'b0, '0, 1'b1);
    drive(1'b0, 1'b1, '0, 1'b1);
    drive(1'b0, 1'b0, '0, 1'b1);

    // Single word through an empty FIFO, then pop it.
    drive(1'b1, 1'b0, 8'h5A, 1'b0);
    drive(1'b0, 1'b0, '0, 1'b0);
    drive(1'b0, 1'b1, '0, 1'b0);

    // Randomized traffic with alternating fill/drain bias.
    for (int i = 0; i < 1500; i++) begin
      if ((i / 40) % 2 == 0) begin wr_pct = 75; rd_pct = 35; end
      else                   begin wr_pct = 35; rd_pct = 75; end
      if ($urandom_range(299, 0) == 0) do_reset();
      drive($urandom_range(99, 0) < wr_pct, $urandom_range(99, 0) < rd_pct,
            DW'($urandom), $urandom_range(19, 0) == 0);
    end
    drive(1'b0, 1'b0, '0, 1'b0);
    drive(1'b0, 1'b0, '0, 1'b0);

    chk("d0_pending_outputs", 32'(exp_q.size()), 32'd0);
    chk("d1_pending_pops", 32'(exp_f.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
